// File: rtl/clock_switch_pkg.sv
// Shared types and widths for the glitch-free clock switch controller.
package clock_switch_pkg;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned COUNT_W = 16;

   typedef enum logic [2:0] {
      STARTUP,
      IDLE,
      DRAIN,
      SWAP,
      RESTORE
   } state_t;

endpackage

// File: rtl/clkswitch_settle_timer.sv
// Settle-phase down-counter; expired is registered and high once the count reaches zero.
module clkswitch_settle_timer
   import clock_switch_pkg::*;
#(
   parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   // expired tracks (count == 0) one register stage ahead of the decrement
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count   <= RESET_VALUE;
         expired <= (RESET_VALUE == '0);
      end else if (load) begin
         count   <= load_value;
         expired <= (load_value == '0);
      end else if (count != '0) begin
         count   <= count - CNT_W'(1);
         expired <= (count == CNT_W'(1));
      end
   end

endmodule

// File: rtl/clock_switch_ctrl.sv
// Clock source switch sequencer: gate off, swap mux select, gate on, acknowledge.
// Optional completed-switch statistics counter enabled by EAGLE_CLKSW_STATS_EN.
module clock_switch_ctrl
   import clock_switch_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic        RESET_SEL     = 1'b0
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               switch_req,
   input  logic               switch_sel,
   output logic               switch_ack,
   output logic               busy,
   output logic               gate_en,
   output logic               mux_sel,
   output logic [COUNT_W-1:0] switch_count
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t state;
   logic   target;
   logic   expired;
   logic   timer_load_c;

   // Every state transition is a state entry and reloads the settle timer
   always_comb begin
      timer_load_c = 1'b0;
      if (state == IDLE) timer_load_c = switch_req && (switch_sel != mux_sel);
      else               timer_load_c = expired;
   end

   clkswitch_settle_timer #(
      .RESET_VALUE (SETTLE_LOAD)
   ) u_settle_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (timer_load_c),
      .load_value (SETTLE_LOAD),
      .expired    (expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= STARTUP;
         gate_en    <= 1'b0;
         mux_sel    <= RESET_SEL;
         busy       <= 1'b1;
         switch_ack <= 1'b0;
         target     <= RESET_SEL;
      end else begin
         switch_ack <= 1'b0;
         case (state)
            STARTUP: if (expired) begin
               gate_en <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            IDLE: if (switch_req) begin
               if (switch_sel == mux_sel) begin
                  switch_ack <= 1'b1;
               end else begin
                  target  <= switch_sel;
                  gate_en <= 1'b0;
                  busy    <= 1'b1;
                  state   <= DRAIN;
               end
            end
            // mux_sel only moves here, with the gate already closed
            DRAIN: if (expired) begin
               mux_sel <= target;
               state   <= SWAP;
            end
            SWAP: if (expired) begin
               gate_en <= 1'b1;
               state   <= RESTORE;
            end
            RESTORE: if (expired) begin
               busy       <= 1'b0;
               switch_ack <= 1'b1;
               state      <= IDLE;
            end
            default: state <= STARTUP;
         endcase
      end
   end

`ifdef EAGLE_CLKSW_STATS_EN
   // Saturating count of completed source changes
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         switch_count <= '0;
      end else if ((state == RESTORE) && expired && (switch_count != '1)) begin
         switch_count <= switch_count + COUNT_W'(1);
      end
   end
`else
   assign switch_count = '0;
`endif

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Randomized bench for clock_switch_ctrl against an edge-arithmetic reference model.
module tb_clock_switch_ctrl;

   localparam int S = 4;

   logic        clock;
   logic        reset_n;
   logic        switch_req;
   logic        switch_sel;
   logic        switch_ack;
   logic        busy;
   logic        gate_en;
   logic        mux_sel;
   logic [15:0] switch_count;

   int checks   = 0;
   int failures = 0;

   // Reference model: edge numbers since reset release at which things happen
   int n;
   int busy_until;
   int gate_off;
   int gate_on;
   int swap_edge;
   int ack_edge;
   int mdl_count;
   logic mux_before;
   logic mux_after;
   logic seq_pending;
   logic prev_mux;
   logic prev_gate;

   clock_switch_ctrl #(
      .SETTLE_CYCLES (S),
      .RESET_SEL     (1'b0)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .switch_req   (switch_req),
      .switch_sel   (switch_sel),
      .switch_ack   (switch_ack),
      .busy         (busy),
      .gate_en      (gate_en),
      .mux_sel      (mux_sel),
      .switch_count (switch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, n, got, exp);
      end
   endtask

   task automatic model_init();
      n           = 0;
      busy_until  = S;
      gate_off    = 0;
      gate_on     = S;
      swap_edge   = 0;
      ack_edge    = -1;
      mdl_count   = 0;
      mux_before  = 1'b0;
      mux_after   = 1'b0;
      seq_pending = 1'b0;
   endtask

   task automatic model_edge(input logic req, input logic sel);
      if (n > busy_until && req) begin
         if (sel == mux_after) begin
            ack_edge = n;
         end else begin
            mux_before  = mux_after;
            mux_after   = sel;
            swap_edge   = n + S;
            gate_off    = n;
            gate_on     = n + 2 * S;
            busy_until  = n + 3 * S;
            ack_edge    = n + 3 * S;
            seq_pending = 1'b1;
         end
      end
      if (seq_pending && n == busy_until) begin
         if (mdl_count < 16'hFFFF) mdl_count++;
         seq_pending = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic exp_gate;
      logic exp_mux;
      int   exp_cnt;
      exp_gate = !(n >= gate_off && n < gate_on);
      exp_mux  = (n >= swap_edge) ? mux_after : mux_before;
`ifdef EAGLE_CLKSW_STATS_EN
      exp_cnt = mdl_count;
`else
      exp_cnt = 0;
`endif
      check_eq("gate_en", 32'(gate_en), 32'(exp_gate));
      check_eq("mux_sel", 32'(mux_sel), 32'(exp_mux));
      check_eq("busy", 32'(busy), 32'(n < busy_until));
      check_eq("switch_ack", 32'(switch_ack), 32'(n == ack_edge));
      check_eq("switch_count", 32'(switch_count), 32'(exp_cnt));
   endtask

   task automatic step(input logic req, input logic sel);
      switch_req = req;
      switch_sel = sel;
      prev_mux   = mux_sel;
      prev_gate  = gate_en;
      @(posedge clock);
      n++;
      model_edge(req, sel);
      #1;
      check_outputs();
      check_eq("mux_moved_gate_open", 32'((mux_sel != prev_mux) && prev_gate), 32'(0));
   endtask

   // Assert reset mid-cycle, check the immediate effect, release on a falling edge
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_init();
      check_outputs();
      @(posedge clock);
      #1;
      check_outputs();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      switch_req = 1'b0;
      switch_sel = 1'b0;
      prev_mux   = 1'b0;
      prev_gate  = 1'b0;
      model_init();
      repeat (2) @(posedge clock);
      #1;
      check_outputs();
      @(negedge clock);
      reset_n = 1'b1;

      // Startup, then a same-source request
      repeat (6) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      // 0->1 switch with a conflicting request at E5 that must be ignored
      step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);

      // Back to 1 then 1->0, interrupted by reset at E6
      step(1'b1, 1'b1);
      repeat (14) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      do_reset();
      repeat (8) step(1'b0, 1'b0);

      // Three real switches and two same-source requests
      for (int k = 0; k < 3; k++) begin
         step(1'b1, ~mux_after);
         repeat (3 * S + 2) step(1'b0, 1'b0);
         if (k < 2) begin
            step(1'b1, mux_after);
            repeat (2) step(1'b0, 1'b0);
         end
      end

      // Random traffic; requesters drop switch_req once acked
      begin
         logic req;
         logic sel;
         req = 1'b0;
         sel = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            if (switch_ack) req = 1'b0;
            else if ($urandom_range(0, 4) == 0) begin
               req = 1'b1;
               sel = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 7) == 0) begin
               req = 1'b0;
            end
            if ($urandom_range(0, 399) == 0) begin
               do_reset();
               req = 1'b0;
            end
            step(req, sel);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_switch_ctrl.md
CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 4: cycles held in each quiet phase of a switch; legal range 1..255.
REQ-002 SHALL provide parameter RESET_SEL, default 1'b0: clock source selected out of reset.
REQ-003 SHALL provide port clock, input, 1: the single controller clock; all state is updated on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL provide port switch_req, input, 1: level request to switch sources; sampled only in IDLE.
REQ-006 SHALL provide port switch_sel, input, 1: target source; sampled with switch_req.
REQ-007 SHALL provide port switch_ack, output, 1: one-cycle completion pulse.
REQ-008 SHALL provide port busy, output, 1: high while a sequence is in progress.
REQ-009 SHALL provide port gate_en, output, 1: registered enable to the downstream clock gater.
REQ-010 SHALL provide port mux_sel, output, 1: registered select to the downstream two-input clock mux.
REQ-011 SHALL provide port switch_count, output, 16: number of completed source changes (see Configuration).

Function
REQ-012 SHALL implement states STARTUP, IDLE, DRAIN, SWAP, RESTORE, with all outputs registered.
REQ-013 SHALL, in STARTUP, hold gate_en=0 for SETTLE_CYCLES cycles, then set gate_en=1 and enter IDLE.
REQ-014 SHALL, in IDLE with switch_req=1 and switch_sel==mux_sel, pulse switch_ack on the next edge and leave gate_en, mux_sel and busy unchanged.
REQ-015 SHALL, in IDLE with switch_req=1 and switch_sel!=mux_sel at edge E0, latch the target, set gate_en=0 and busy=1, and enter DRAIN.
REQ-016 SHALL, at edge E0+SETTLE_CYCLES, update mux_sel to the target and enter SWAP.
REQ-017 SHALL, at edge E0+2*SETTLE_CYCLES, set gate_en=1 and enter RESTORE.
REQ-018 SHALL, at edge E0+3*SETTLE_CYCLES, return to IDLE with busy=0 and switch_ack=1 for exactly one cycle.
REQ-019 SHALL never change mux_sel while gate_en=1.
REQ-020 SHALL ignore switch_req and switch_sel outside IDLE; a target latched at E0 is immutable until completion.
REQ-021 SHALL treat a switch_req still high in the cycle after switch_ack as a new request; requesters drop switch_req on switch_ack.
REQ-022 SHALL use an 8-bit down-counter for the settle phases, reloaded with SETTLE_CYCLES-1 on each state entry.

Reset
REQ-023 SHALL, while reset_n=0, immediately force: state STARTUP, gate_en=0, mux_sel=RESET_SEL, busy=1, switch_ack=0, counter reloaded, switch_count=0.
REQ-024 SHALL abandon an in-flight sequence on reset without generating switch_ack.
REQ-025 SHALL, after reset release, follow REQ-013; busy falls when IDLE is entered.

Configuration
REQ-026 SHALL, with EAGLE_CLKSW_STATS_EN defined, increment switch_count at each REQ-018 completion, saturating at 16'hFFFF; same-source acks (REQ-014) do not count.
REQ-027 SHALL, without EAGLE_CLKSW_STATS_EN, drive switch_count constant 0 and contain no counter logic.

Structure
REQ-028 SHALL place the state enumeration, the 8-bit counter width constant and the switch_count width constant in shared package clock_switch_pkg.
REQ-029 SHALL implement the settle counter as sub-module clkswitch_settle_timer (inputs load and load value; output expired).

Verification (SETTLE_CYCLES=4, RESET_SEL=0)
REQ-030 SHALL check reset release: gate_en=0 for 4 edges, rises at the 4th edge, busy falls with it; mux_sel=0 throughout.
REQ-031 SHALL check a 0->1 switch requested at E0: gate_en falls at E0, mux_sel=1 at E4, gate_en=1 at E8, switch_ack pulses at E12, busy high E0..E11.
REQ-032 SHALL check switch_req with switch_sel=0 while mux_sel=0: single switch_ack the next cycle; gate_en stays 1, busy stays 0.
REQ-033 SHALL check that switch_req with switch_sel=0 asserted at E5 of a 0->1 switch is ignored: the sequence completes to mux_sel=1, and the request is honoured only after returning to IDLE.
REQ-034 SHALL check that reset_n asserted at E6 of a switch immediately gives gate_en=0, mux_sel=0, no switch_ack, and a rerun of STARTUP.
REQ-035 SHALL check, with EAGLE_CLKSW_STATS_EN, that 3 real switches plus 2 same-source requests give switch_count=3, and that it is 0 after reset.
